// File: rtl/ras_ckpt.sv
// Speculative return-address stack with in-order checkpoints for the fetch predictor.
// A checkpoint snapshots {tos_ptr, count, top entry}; a mispredict restores one in a single cycle.
module ras_ckpt #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int NCKPT = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       empty,
    input  logic                       ckpt_req,
    output logic                       ckpt_ready,
    output logic [$clog2(NCKPT)-1:0]   ckpt_tag,
    input  logic                       commit,
    input  logic                       restore,
    input  logic [$clog2(NCKPT)-1:0]   restore_tag,
    output logic [7:0]                 ovf_cnt,
    output logic                       err
);

    localparam int PW = $clog2(DEPTH);
    localparam int TW = $clog2(NCKPT);

    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
    localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);
    localparam logic [TW-1:0] TAG_ONE  = TW'(1);
    localparam logic [TW:0]   USED_ONE = (TW+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    tos_ptr;
    logic [PW:0]      count;

    logic [PW-1:0]    slot_ptr [NCKPT];
    logic [PW:0]      slot_cnt [NCKPT];
    logic [WIDTH-1:0] slot_top [NCKPT];

    logic [TW-1:0]    head;
    logic [TW-1:0]    tail;
    logic [TW:0]      ckpt_used;

    logic             restore_ok;
    logic             rv;
    logic             alloc;
    logic             commit_ok;
    logic             err_set;
    logic             ovf_inc;
    logic             mem_we;
    logic [PW-1:0]    mem_waddr;
    logic [WIDTH-1:0] mem_wdata;
    logic [PW-1:0]    nxt_ptr;
    logic [PW:0]      nxt_cnt;
    logic [WIDTH-1:0] nxt_top;
    logic [TW-1:0]    nxt_head;
    logic [TW-1:0]    nxt_tail;
    logic [TW:0]      nxt_used;
    logic [TW-1:0]    rs_off;

    assign dout       = (count == '0) ? '0 : mem[tos_ptr];
    assign empty      = (count == '0);
    assign ckpt_ready = !ckpt_used[TW];
    assign ckpt_tag   = tail;

    // Membership in [head, tail) is judged on ckpt_used so a full ring (head == tail) still works.
    assign rs_off     = restore_tag - head;
    assign restore_ok = ({1'b0, rs_off} < ckpt_used);
    assign rv         = restore && restore_ok;
    assign commit_ok  = commit && (ckpt_used != '0);
    assign alloc      = !rv && ckpt_req && ckpt_ready;

    always_comb begin
        nxt_ptr   = tos_ptr;
        nxt_cnt   = count;
        mem_we    = 1'b0;
        mem_waddr = tos_ptr;
        mem_wdata = din;
        ovf_inc   = 1'b0;
        err_set   = 1'b0;

        if (rv) begin
            nxt_ptr   = slot_ptr[restore_tag];
            nxt_cnt   = slot_cnt[restore_tag];
            mem_we    = 1'b1;
            mem_waddr = slot_ptr[restore_tag];
            mem_wdata = slot_top[restore_tag];
        end else if (push && pop && (count != '0)) begin
            mem_we = 1'b1;
        end else if (push) begin
            nxt_ptr   = tos_ptr + PTR_ONE;
            mem_we    = 1'b1;
            mem_waddr = tos_ptr + PTR_ONE;
            if (count == CNT_FULL) begin
                ovf_inc = 1'b1;
            end else begin
                nxt_cnt = count + CNT_ONE;
            end
        end else if (pop) begin
            if (count != '0) begin
                nxt_ptr = tos_ptr - PTR_ONE;
                nxt_cnt = count - CNT_ONE;
            end else begin
                err_set = 1'b1;
            end
        end

        // Snapshot must see this cycle's write, which is not yet in the array.
        nxt_top = (mem_we && (mem_waddr == nxt_ptr)) ? mem_wdata : mem[nxt_ptr];

        if (!rv && ckpt_req && !ckpt_ready) begin
            err_set = 1'b1;
        end
        if (commit && (ckpt_used == '0)) begin
            err_set = 1'b1;
        end
        if (restore && !restore_ok) begin
            err_set = 1'b1;
        end

        nxt_head = commit_ok ? head + TAG_ONE : head;
        nxt_tail = tail;
        nxt_used = ckpt_used;
        if (rv) begin
            // Commit retires first; when it retires the restored slot too, nothing stays live.
            if (commit_ok && (restore_tag == head)) begin
                nxt_tail = restore_tag + TAG_ONE;
                nxt_used = '0;
            end else begin
                nxt_tail = restore_tag;
                nxt_used = {1'b0, restore_tag - nxt_head};
            end
        end else begin
            if (alloc) begin
                nxt_tail = tail + TAG_ONE;
            end
            case ({alloc, commit_ok})
                2'b10:   nxt_used = ckpt_used + USED_ONE;
                2'b01:   nxt_used = ckpt_used - USED_ONE;
                default: nxt_used = ckpt_used;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tos_ptr   <= PTR_LAST;
            count     <= '0;
            head      <= '0;
            tail      <= '0;
            ckpt_used <= '0;
            ovf_cnt   <= '0;
            err       <= 1'b0;
        end else begin
            tos_ptr   <= nxt_ptr;
            count     <= nxt_cnt;
            head      <= nxt_head;
            tail      <= nxt_tail;
            ckpt_used <= nxt_used;
            if (ovf_inc && (ovf_cnt != '1)) begin
                ovf_cnt <= ovf_cnt + 8'd1;
            end
            if (err_set) begin
                err <= 1'b1;
            end
            if (mem_we) begin
                mem[mem_waddr] <= mem_wdata;
            end
            if (alloc) begin
                slot_ptr[tail] <= nxt_ptr;
                slot_cnt[tail] <= nxt_cnt;
                slot_top[tail] <= nxt_top;
            end
        end
    end

endmodule

// File: tb/tb_ras_ckpt.sv
// Directed bench for ras_ckpt: a vector table of per-cycle stimulus with expected post-edge
// outputs, plus looped sequences for stack overflow and a full checkpoint ring.
module tb_ras_ckpt;

    logic        clk = 1'b0;
    logic        reset;
    logic        push;
    logic        pop;
    logic [31:0] din;
    logic [31:0] dout;
    logic        empty;
    logic        ckpt_req;
    logic        ckpt_ready;
    logic [2:0]  ckpt_tag;
    logic        commit;
    logic        restore;
    logic [2:0]  restore_tag;
    logic [7:0]  ovf_cnt;
    logic        err;

    int checks   = 0;
    int failures = 0;

    ras_ckpt #(.WIDTH(32), .DEPTH(16), .NCKPT(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .push        (push),
        .pop         (pop),
        .din         (din),
        .dout        (dout),
        .empty       (empty),
        .ckpt_req    (ckpt_req),
        .ckpt_ready  (ckpt_ready),
        .ckpt_tag    (ckpt_tag),
        .commit      (commit),
        .restore     (restore),
        .restore_tag (restore_tag),
        .ovf_cnt     (ovf_cnt),
        .err         (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, psh, pp;
        logic [31:0] d;
        logic        req, cmt, rs;
        logic [2:0]  rtag;
        logic [31:0] e_dout;
        logic        e_empty, e_ready;
        logic [2:0]  e_tag;
        logic [7:0]  e_ovf;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic psh, logic pp, logic [31:0] d, logic req,
                                logic cmt, logic rs, logic [2:0] rtag, logic [31:0] e_dout,
                                logic e_empty, logic e_ready, logic [2:0] e_tag,
                                logic [7:0] e_ovf, logic e_err);
        vec_t v;
        v.rst = rst; v.psh = psh; v.pp = pp; v.d = d; v.req = req; v.cmt = cmt;
        v.rs = rs; v.rtag = rtag; v.e_dout = e_dout; v.e_empty = e_empty;
        v.e_ready = e_ready; v.e_tag = e_tag; v.e_ovf = e_ovf; v.e_err = e_err;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] actual=%0h required=%0h", name, idx, act, exp);
        end
    endtask

    task automatic step(input logic rst, input logic psh, input logic pp, input logic [31:0] d,
                        input logic req, input logic cmt, input logic rs, input logic [2:0] rtag);
        reset = rst; push = psh; pop = pp; din = d;
        ckpt_req = req; commit = cmt; restore = rs; restore_tag = rtag;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 3'd0);
    endtask

    initial begin
        //            rst psh pop din       req cmt rs tag  dout      emp rdy tag ovf err
        // basic push/pop
        vecs.push_back(mk(1, 0, 0, 32'h0,   0, 0, 0, 0,   32'h0,    1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 32'h100, 0, 0, 0, 0,   32'h100,  0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 32'h200, 0, 0, 0, 0,   32'h200,  0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 32'h300, 0, 0, 0, 0,   32'h300,  0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 32'h0,   0, 0, 0, 0,   32'h200,  0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 32'h0,   0, 0, 0, 0,   32'h100,  0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 32'h0,   0, 0, 0, 0,   32'h0,    1, 1, 0, 0, 0));
        // checkpoint, speculate, restore
        vecs.push_back(mk(1, 0, 0, 32'h0,   0, 0, 0, 0,   32'h0,    1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 32'hA,   0, 0, 0, 0,   32'hA,    0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,   1, 0, 0, 0,   32'hA,    0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 32'h0,   0, 0, 0, 0,   32'h0,    1, 1, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 32'hB,   0, 0, 0, 0,   32'hB,    0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 32'hC,   0, 0, 0, 0,   32'hC,    0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,   0, 0, 1, 0,   32'hA,    0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 32'h0,   0, 0, 0, 0,   32'h0,    1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,   0, 1, 0, 0,   32'h0,    1, 1, 0, 0, 1));
        // four live checkpoints, restore tag2 with a discarded push, then stale tag3
        vecs.push_back(mk(1, 0, 0, 32'h0,   0, 0, 0, 0,   32'h0,    1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 32'h10,  1, 0, 0, 0,   32'h10,   0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 32'h20,  1, 0, 0, 0,   32'h20,   0, 1, 2, 0, 0));
        vecs.push_back(mk(0, 1, 0, 32'h30,  1, 0, 0, 0,   32'h30,   0, 1, 3, 0, 0));
        vecs.push_back(mk(0, 1, 0, 32'h40,  1, 0, 0, 0,   32'h40,   0, 1, 4, 0, 0));
        vecs.push_back(mk(0, 1, 0, 32'h99,  1, 0, 1, 2,   32'h30,   0, 1, 2, 0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,   0, 0, 1, 3,   32'h30,   0, 1, 2, 0, 1));
        vecs.push_back(mk(0, 0, 1, 32'h0,   0, 0, 0, 0,   32'h20,   0, 1, 2, 0, 1));
        // reset overriding other inputs, then commit + restore on the head slot
        vecs.push_back(mk(1, 1, 0, 32'h55,  1, 1, 0, 0,   32'h0,    1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 32'h5,   1, 0, 0, 0,   32'h5,    0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 32'h6,   1, 0, 0, 0,   32'h6,    0, 1, 2, 0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,   0, 1, 1, 0,   32'h5,    0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,   1, 0, 0, 0,   32'h5,    0, 1, 2, 0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,   0, 1, 0, 0,   32'h5,    0, 1, 2, 0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,   0, 1, 0, 0,   32'h5,    0, 1, 2, 0, 1));
        // simultaneous push/pop
        vecs.push_back(mk(1, 0, 0, 32'h0,   0, 0, 0, 0,   32'h0,    1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 32'h77,  0, 0, 0, 0,   32'h77,   0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 32'h88,  0, 0, 0, 0,   32'h88,   0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 32'h0,   0, 0, 0, 0,   32'h0,    1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 32'h0,   0, 0, 0, 0,   32'h0,    1, 1, 0, 0, 1));

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].psh, vecs[i].pp, vecs[i].d,
                 vecs[i].req, vecs[i].cmt, vecs[i].rs, vecs[i].rtag);
            chk("vec_dout",  i, dout,              vecs[i].e_dout);
            chk("vec_empty", i, 32'(empty),        32'(vecs[i].e_empty));
            chk("vec_ready", i, 32'(ckpt_ready),   32'(vecs[i].e_ready));
            chk("vec_tag",   i, 32'(ckpt_tag),     32'(vecs[i].e_tag));
            chk("vec_ovf",   i, 32'(ovf_cnt),      32'(vecs[i].e_ovf));
            chk("vec_err",   i, 32'(err),          32'(vecs[i].e_err));
        end

        // overflow: 17 pushes into 16 entries, drain, then underflow
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 3'd0);
        for (int i = 0; i < 17; i++) begin
            step(1'b0, 1'b1, 1'b0, 32'(i), 1'b0, 1'b0, 1'b0, 3'd0);
        end
        chk("ovf_cnt1", 0, 32'(ovf_cnt), 32'd1);
        chk("ovf_top",  0, dout, 32'd16);
        for (int k = 1; k <= 16; k++) begin
            step(1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 3'd0);
            chk("drain_dout",  k, dout, (k < 16) ? 32'(16 - k) : 32'd0);
            chk("drain_empty", k, 32'(empty), (k == 16) ? 32'd1 : 32'd0);
        end
        chk("drain_err", 0, 32'(err), 32'd0);
        step(1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 3'd0);
        chk("underflow_err",   0, 32'(err), 32'd1);
        chk("underflow_empty", 0, 32'(empty), 32'd1);
        chk("underflow_ovf",   0, 32'(ovf_cnt), 32'd1);
        for (int i = 0; i < 300; i++) begin
            step(1'b0, 1'b1, 1'b0, 32'(i + 1000), 1'b0, 1'b0, 1'b0, 3'd0);
        end
        chk("ovf_sat",     0, 32'(ovf_cnt), 32'd255);
        chk("ovf_sat_top", 0, dout, 32'd1299);

        // full checkpoint ring
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 3'd0);
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 3'd0);
            chk("fill_tag",   i, 32'(ckpt_tag), 32'(i % 8));
            chk("fill_ready", i, 32'(ckpt_ready), (i < 8) ? 32'd1 : 32'd0);
        end
        chk("fill_err", 0, 32'(err), 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 3'd0);
        chk("full_req_err",   0, 32'(err), 32'd1);
        chk("full_req_ready", 0, 32'(ckpt_ready), 32'd0);
        chk("full_req_tag",   0, 32'(ckpt_tag), 32'd0);
        // full ring: commit retires one, the request is still refused
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 3'd0);
        chk("full_cmt_ready", 0, 32'(ckpt_ready), 32'd1);
        chk("full_cmt_tag",   0, 32'(ckpt_tag), 32'd0);
        // seven live: commit + request balance out
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 3'd0);
        chk("bal_ready", 0, 32'(ckpt_ready), 32'd1);
        chk("bal_tag",   0, 32'(ckpt_tag), 32'd1);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 3'd0);
        chk("refill_ready", 0, 32'(ckpt_ready), 32'd0);
        chk("refill_tag",   0, 32'(ckpt_tag), 32'd2);
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
